rate_strobe_gen: RTL and testbench

RATE_STROBE_GEN -- requirements
Module: rate_strobe_gen

---
 rtl/rate_strobe_pkg.sv | 21 ++
 rtl/clock_divider.sv | 29 ++
 rtl/rate_strobe_gen_rise_detect.sv | 31 +++
 rtl/rate_strobe_gen.sv | 142 ++++++++++++++
 tb/tb_rate_strobe_gen.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rate_strobe_pkg.sv
// Shared types for the rate strobe generator: FSM states, rate indices.
// No logic; types and constants only.
// No flow control.
package rate_strobe_pkg;

    localparam int N_RATES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RATE_2  = 2'd0,
        RATE_4  = 2'd1,
        RATE_8  = 2'd2,
        RATE_16 = 2'd3
    } rate_t;

endpackage

// File: rtl/clock_divider.sv
// Free-running binary counter; bit k toggles at clk / 2^(k+1).
// Latency: outputs are registered, counter starts at 0 after reset.
// No flow control; runs every cycle.
module clock_divider #(
    parameter int WIDTH_REG = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    output logic [WIDTH_REG-1:0] div_out
);

    logic [WIDTH_REG-1:0] cnt_q;
    logic [WIDTH_REG-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + WIDTH_REG'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign div_out = cnt_q;

endmodule

// File: rtl/rate_strobe_gen_rise_detect.sv
// Per-bit rising-edge detector: rise = sig_in & ~previous sample.
// Latency: combinational rise against a one-cycle-old register (resets to all ones).
// No flow control; samples every cycle.
module rise_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    // All-ones reset: a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sig_q <= '1;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/rate_strobe_gen.sv
// Strobe generator locked to a selectable divided clock, with glitch-free rate switching.
// Latency: strobe one cycle after the selected divider edge; sel_ack one cycle after acceptance.
// Backpressure: sel_req is held until sel_ack; strobe_cnt only exists with RATE_STROBE_CNT_EN.
module rate_strobe_gen
    import rate_strobe_pkg::*;
#(
    parameter int WIDTH_CNT = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [3:0]           div_in,
    input  logic                 en,
    input  logic                 sel_req,
    input  logic [1:0]           sel_val,
    input  logic                 cnt_clr,
    output logic                 sel_ack,
    output logic                 strobe,
    output logic [1:0]           rate_cur,
    output logic                 active,
    output logic [WIDTH_CNT-1:0] strobe_cnt
);

    state_t               state_q, state_d;
    rate_t                rate_q, rate_d;
    rate_t                pend_q, pend_d;
    logic                 strobe_q, strobe_d;
    logic                 ack_q, ack_d;
    logic                 req_ok;
    logic [N_RATES-1:0]   rise_vec;
    logic                 rise_sel;

    rise_detect #(
        .WIDTH (N_RATES)
    ) u_rise (
        .clk    (clk),
        .n_rst  (n_rst),
        .sig_in (div_in),
        .rise   (rise_vec)
    );

    assign rise_sel = rise_vec[rate_q];

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        pend_d   = pend_q;
        strobe_d = 1'b0;
        ack_d    = 1'b0;
        // A request still visible during its own ack cycle is the same request.
        req_ok   = sel_req & ~ack_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    rate_d = rate_t'(sel_val);
                    ack_d  = 1'b1;
                end else if (en && !sel_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    strobe_d = rise_sel;
                    if (req_ok) begin
                        if (rate_t'(sel_val) == rate_q) begin
                            ack_d = 1'b1;
                        end else begin
                            pend_d  = rate_t'(sel_val);
                            state_d = SWITCH;
                        end
                    end
                end
            end
            SWITCH: begin
                if (!en) begin
                    rate_d  = pend_q;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (rise_sel) begin
                    strobe_d = 1'b1;
                    rate_d   = pend_q;
                    ack_d    = 1'b1;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            rate_q   <= RATE_2;
            pend_q   <= RATE_2;
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            pend_q   <= pend_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
        end
    end

    assign sel_ack  = ack_q;
    assign strobe   = strobe_q;
    assign rate_cur = rate_q;
    assign active   = (state_q == RUN) || (state_q == SWITCH);

`ifdef RATE_STROBE_CNT_EN
    logic [WIDTH_CNT-1:0] cnt_q;
    logic [WIDTH_CNT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (strobe_q) begin
            cnt_d = cnt_q + WIDTH_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign strobe_cnt     = '0;
`endif

endmodule

// File: tb/tb_rate_strobe_gen.sv
// Directed bench for rate_strobe_gen driven by a real clock_divider, checked every cycle
// against an arithmetic model plus hand-computed scenario expectations.
module tb_rate_strobe_gen;

`ifdef RATE_STROBE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        n_rst;
    logic        div_rst_n;
    logic [3:0]  div_in;
    logic        en;
    logic        sel_req;
    logic [1:0]  sel_val;
    logic        cnt_clr;
    logic        sel_ack, strobe, active;
    logic [1:0]  rate_cur;
    logic [15:0] strobe_cnt;
    logic        sel_ack4, strobe4, active4;
    logic [1:0]  rate_cur4;
    logic [3:0]  strobe_cnt4;

    int n_chk = 0;
    int n_fail = 0;

    clock_divider #(.WIDTH_REG(4)) u_div (
        .clk     (clk),
        .n_rst   (div_rst_n),
        .div_out (div_in)
    );

    rate_strobe_gen dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .div_in     (div_in),
        .en         (en),
        .sel_req    (sel_req),
        .sel_val    (sel_val),
        .cnt_clr    (cnt_clr),
        .sel_ack    (sel_ack),
        .strobe     (strobe),
        .rate_cur   (rate_cur),
        .active     (active),
        .strobe_cnt (strobe_cnt)
    );

    rate_strobe_gen #(.WIDTH_CNT(4)) dut4 (
        .clk        (clk),
        .n_rst      (n_rst),
        .div_in     (div_in),
        .en         (en),
        .sel_req    (sel_req),
        .sel_val    (sel_val),
        .cnt_clr    (cnt_clr),
        .sel_ack    (sel_ack4),
        .strobe     (strobe4),
        .rate_cur   (rate_cur4),
        .active     (active4),
        .strobe_cnt (strobe_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: divider value is the number of clk edges since divider reset (mod 16);
    // the selected divided clock rises when v mod period == period/2.
    int tick;
    always @(posedge clk or negedge div_rst_n) begin
        if (!div_rst_n) tick <= 0;
        else            tick <= tick + 1;
    end

    bit m_run = 0, m_fresh = 1, m_strobe = 0, m_ack = 0;
    int m_pend = -1, m_rate = 0, m_cnt = 0;
    int v, per;
    bit rise, accept;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_run = 0; m_fresh = 1; m_strobe = 0; m_ack = 0;
            m_pend = -1; m_rate = 0; m_cnt = 0;
        end else begin
            v      = tick % 16;
            per    = 2 << m_rate;
            rise   = !m_fresh && ((v % per) == (per / 2));
            m_fresh = 0;
            if (cnt_clr)       m_cnt = 0;
            else if (m_strobe) m_cnt = m_cnt + 1;
            accept   = sel_req && !m_ack;
            m_strobe = 0;
            m_ack    = 0;
            if (!m_run) begin
                if (accept) begin
                    m_rate = int'(sel_val);
                    m_ack  = 1;
                end else if (en && !sel_req) begin
                    m_run = 1;
                end
            end else if (!en) begin
                if (m_pend >= 0) begin
                    m_rate = m_pend;
                    m_ack  = 1;
                end
                m_run  = 0;
                m_pend = -1;
            end else if (m_pend >= 0) begin
                if (rise) begin
                    m_strobe = 1;
                    m_rate   = m_pend;
                    m_pend   = -1;
                    m_ack    = 1;
                end
            end else begin
                m_strobe = rise;
                if (accept) begin
                    if (int'(sel_val) == m_rate) m_ack = 1;
                    else                          m_pend = int'(sel_val);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("strobe", strobe, m_strobe);
        chk("strobe_w4", strobe4, m_strobe);
        chk("sel_ack", sel_ack, m_ack);
        chk("rate_cur", rate_cur, m_rate);
        chk("active", active, m_run);
        chk("strobe_cnt", strobe_cnt, CNT_ON ? (m_cnt % 65536) : 0);
        chk("strobe_cnt_w4", strobe_cnt4, CNT_ON ? (m_cnt % 16) : 0);
    end

    task automatic wait_strobe(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (strobe !== 1'b1 && n < max_cyc);
        chk("strobe_seen", strobe, 1);
    endtask

    int n, t_ack, exp_gap;

    initial begin
        n_rst = 1'b1; div_rst_n = 1'b1;
        en = 1'b0; sel_req = 1'b0; sel_val = 2'd0; cnt_clr = 1'b0;
        #1 n_rst = 1'b0; div_rst_n = 1'b0;
        #6;
        chk("rst_strobe", strobe, 0);
        chk("rst_ack", sel_ack, 0);
        chk("rst_rate", rate_cur, 0);
        chk("rst_active", active, 0);
        chk("rst_cnt", strobe_cnt, 0);
        #3 n_rst = 1'b1; div_rst_n = 1'b1;
        #1;
        @(negedge clk);

        // Scenario 1: default rate /2
        en = 1'b1;
        wait_strobe(10, n);
        chk("s1_first_latency", n, 3);
        for (int i = 0; i < 19; i++) begin
            wait_strobe(4, n);
            chk("s1_gap", n, 2);
        end
        @(negedge clk);
        chk("s1_cnt20", strobe_cnt, CNT_ON ? 20 : 0);
        chk("s1_cnt20_w4", strobe_cnt4, CNT_ON ? 4 : 0);
        en = 1'b0;
        @(negedge clk);
        chk("s1_off_strobe", strobe, 0);
        chk("s1_off_active", active, 0);

        // Scenario 2: switch while idle to /16
        sel_req = 1'b1; sel_val = 2'd3;
        @(negedge clk);
        chk("s2_ack", sel_ack, 1);
        chk("s2_rate", rate_cur, 3);
        sel_req = 1'b0;
        @(negedge clk);
        chk("s2_ack_one_cycle", sel_ack, 0);
        en = 1'b1;
        wait_strobe(40, n);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(20, n);
            chk("s2_gap16", n, 16);
        end

        // Scenario 3: switch /4 -> /8 while running
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sel_req = 1'b1; sel_val = 2'd1;
        @(negedge clk);
        chk("s3_ack_idle", sel_ack, 1);
        chk("s3_rate1", rate_cur, 1);
        sel_req = 1'b0; en = 1'b1;
        wait_strobe(20, n);
        wait_strobe(8, n);
        chk("s3_gap4", n, 4);
        sel_req = 1'b1; sel_val = 2'd2;
        wait_strobe(8, n);
        chk("s3_last_old_gap", n, 4);
        chk("s3_ack_with_strobe", sel_ack, 1);
        chk("s3_rate2", rate_cur, 2);
        t_ack = tick;
        sel_req = 1'b0;
        exp_gap = (12 - ((t_ack - 1) % 8)) % 8;
        wait_strobe(10, n);
        chk("s3_first_new_gap", n, exp_gap);
        wait_strobe(10, n);
        chk("s3_gap8", n, 8);

        // Same-rate request while running: immediate ack, stays running
        sel_req = 1'b1; sel_val = 2'd2;
        @(negedge clk);
        chk("s3b_ack", sel_ack, 1);
        chk("s3b_active", active, 1);
        sel_req = 1'b0;

        // Scenario 4: en dropped while switching
        wait_strobe(10, n);
        chk("s4_gap", n, 7);
        sel_req = 1'b1; sel_val = 2'd0;
        @(negedge clk);
        chk("s4_switch_active", active, 1);
        chk("s4_switch_noack", sel_ack, 0);
        en = 1'b0;
        @(negedge clk);
        chk("s4_ack", sel_ack, 1);
        chk("s4_strobe", strobe, 0);
        chk("s4_active", active, 0);
        chk("s4_rate", rate_cur, 0);
        sel_req = 1'b0;
        @(negedge clk);

        // Scenario 5: counter wrap and clear priority
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("s5_clr", strobe_cnt, 0);
        en = 1'b1;
        for (int i = 0; i < 16; i++) wait_strobe(8, n);
        chk("s5_cnt15_w4", strobe_cnt4, CNT_ON ? 15 : 0);
        @(negedge clk);
        chk("s5_wrap_w4", strobe_cnt4, 0);
        chk("s5_cnt16", strobe_cnt, CNT_ON ? 16 : 0);
        wait_strobe(4, n);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("s5_clr_prio", strobe_cnt, 0);
        chk("s5_clr_prio_w4", strobe_cnt4, 0);

        // Scenario 6: reset asserted mid-switch
        wait_strobe(4, n);
        sel_req = 1'b1; sel_val = 2'd3;
        @(negedge clk);
        chk("s6_in_switch", active, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("s6_rst_strobe", strobe, 0);
        chk("s6_rst_ack", sel_ack, 0);
        chk("s6_rst_rate", rate_cur, 0);
        chk("s6_rst_active", active, 0);
        chk("s6_rst_cnt", strobe_cnt, 0);
        sel_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk("s6_no_ack", sel_ack, 0);
        chk("s6_rate0", rate_cur, 0);
        chk("s6_running", active, 1);
        wait_strobe(6, n);
        chk("s6_first_strobe", n, 2);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
